// File: rtl/cross_bar_mem_slave_if.sv
// Crossbar slave-port bundle: req/addr/cmd/wdata toward the slave, ack/resp/rdata/busy back.
// addr_err exists only when MEM_SLAVE_ADDR_CHECK_EN is defined.
interface cross_bar_mem_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  cmd;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic                  resp;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
`ifdef MEM_SLAVE_ADDR_CHECK_EN
  logic                  addr_err;

  modport master (output req, addr, cmd, wdata, input ack, resp, rdata, busy, addr_err);
  modport slave  (input req, addr, cmd, wdata, output ack, resp, rdata, busy, addr_err);
`else
  modport master (output req, addr, cmd, wdata, input ack, resp, rdata, busy);
  modport slave  (input req, addr, cmd, wdata, output ack, resp, rdata, busy);
`endif
endinterface

// File: rtl/cross_bar_mem_slave.sv
// Memory-backed crossbar slave: one transaction at a time, programmable ack/resp latency.
// Optional out-of-range address checking with sticky addr_err: MEM_SLAVE_ADDR_CHECK_EN.
module cross_bar_mem_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned ACK_DELAY  = 1,
  parameter int unsigned RESP_DELAY = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  cross_bar_mem_slave_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned MAX_D = (ACK_DELAY > RESP_DELAY) ? ACK_DELAY : RESP_DELAY;
  localparam int unsigned CNT_W = $clog2(MAX_D + 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RESP, DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_cmd;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rword, w_rword_nxt;
  logic                  r_ack, r_resp, r_busy;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic                  w_ack_nxt, w_resp_nxt;
  logic                  w_capture, w_mem_we, w_latch;
  logic                  w_addr_hi, w_oor;
  logic [DATA_WIDTH-1:0] w_mem_rd;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  assign w_addr_hi = |(bus.addr >> IDX_W);

`ifdef MEM_SLAVE_ADDR_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] ERR_WORD = {(DATA_WIDTH/4){4'hE}};
  logic r_oor, r_addr_err;

  assign w_oor        = r_oor;
  assign w_mem_rd     = r_oor ? ERR_WORD : r_mem[r_idx];
  assign bus.addr_err = r_addr_err;

  // Sticky error flag rises together with the ack of the first out-of-range access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oor      <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_capture) r_oor <= w_addr_hi;
      if (w_ack_nxt && (w_capture ? w_addr_hi : r_oor)) r_addr_err <= 1'b1;
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = w_addr_hi;
  assign w_oor       = 1'b0;
  assign w_mem_rd    = r_mem[r_idx];
`endif

  // Next-state, counter and registered-output staging
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_mem_we    = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_capture   = 1'b1;
          w_state_nxt = WAIT_ACK;
          w_cnt_nxt   = CNT_W'(ACK_DELAY - 1);
        end
      end
      WAIT_ACK: begin
        if (r_cnt == '0) begin
          if (r_cmd) begin
            w_mem_we    = ~w_oor;
            w_state_nxt = DONE;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = WAIT_RESP;
            w_cnt_nxt   = CNT_W'(RESP_DELAY - 1);
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      WAIT_RESP: begin
        if (r_cnt == '0) w_state_nxt = DONE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_ack_nxt   = (w_state_nxt == WAIT_ACK)  && (w_cnt_nxt == '0);
    w_resp_nxt  = (w_state_nxt == WAIT_RESP) && (w_cnt_nxt == '0);
    w_rword_nxt = w_latch ? w_mem_rd : r_rword;
    w_rdata_nxt = w_resp_nxt ? w_rword_nxt : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_cmd   <= 1'b0;
      r_wdata <= '0;
      r_rword <= '0;
      r_ack   <= 1'b0;
      r_resp  <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rword <= w_rword_nxt;
      r_ack   <= w_ack_nxt;
      r_resp  <= w_resp_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_rdata <= w_rdata_nxt;
      if (w_capture) begin
        r_idx   <= bus.addr[IDX_W-1:0];
        r_cmd   <= bus.cmd;
        r_wdata <= bus.wdata;
      end
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_idx] <= r_wdata;
  end

  assign bus.ack   = r_ack;
  assign bus.resp  = r_resp;
  assign bus.rdata = r_rdata;
  assign bus.busy  = r_busy;
endmodule

// File: tb/tb_cross_bar_mem_slave.sv
// Directed bench: dut0 with default latencies, dut1 with ACK_DELAY=3 / RESP_DELAY=4.
module tb_cross_bar_mem_slave;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cross_bar_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
  cross_bar_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

  cross_bar_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256),
                        .ACK_DELAY(1), .RESP_DELAY(1))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  cross_bar_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256),
                        .ACK_DELAY(3), .RESP_DELAY(4))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input bit sel, input bit r, input bit c,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if0.addr = a;  if1.addr = a;
    if0.cmd = c;   if1.cmd = c;
    if0.wdata = d; if1.wdata = d;
    if (sel) if1.req = r;
    else     if0.req = r;
  endtask

  // One transaction on dut0 (sel=0) or dut1 (sel=1); chg rewrites inputs right after capture
  task automatic txn(input bit sel, input bit c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit chg, input logic [DW-1:0] d2, input logic [DW-1:0] exp_rd,
                     input string tag);
    int ack_at, resp_at, acks, resps, busy_n, rd_bad, ad, rl;
    logic [DW-1:0] rd_val;
    logic o_ack, o_resp, o_busy;
    logic [DW-1:0] o_rdata;
    ad = sel ? 3 : 1;
    rl = sel ? 4 : 1;
    ack_at = 0; resp_at = 0; acks = 0; resps = 0; busy_n = 0; rd_bad = 0; rd_val = '0;
    @(posedge clk); #1;
    drive(sel, 1'b1, c, a, d);
    @(posedge clk);
    if (chg) begin
      #1;
      drive(sel, 1'b1, ~c, a ^ 32'h1, d2);
    end
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      o_ack   = sel ? if1.ack   : if0.ack;
      o_resp  = sel ? if1.resp  : if0.resp;
      o_busy  = sel ? if1.busy  : if0.busy;
      o_rdata = sel ? if1.rdata : if0.rdata;
      if (o_ack) begin
        acks++;
        if (ack_at == 0) ack_at = n;
        if (sel) if1.req = 1'b0;
        else     if0.req = 1'b0;
      end
      if (o_resp) begin
        resps++;
        resp_at = n;
        rd_val  = o_rdata;
      end else if (o_rdata !== '0) begin
        rd_bad++;
      end
      if (o_busy) busy_n++;
    end
    check({tag, ".ack_at"},  64'(ack_at),  64'(ad));
    check({tag, ".acks"},    64'(acks),    64'd1);
    check({tag, ".resp_at"}, 64'(resp_at), c ? 64'd0 : 64'(ad + rl));
    check({tag, ".resps"},   64'(resps),   c ? 64'd0 : 64'd1);
    if (!c) check({tag, ".rdata"}, 64'(rd_val), 64'(exp_rd));
    check({tag, ".rdata_idle"}, 64'(rd_bad), 64'd0);
    check({tag, ".busy_cyc"},   64'(busy_n), c ? 64'(ad + 1) : 64'(ad + rl + 1));
  endtask

  initial begin
    int a1, a2, late_resp;
    if0.req = 1'b0;
    if1.req = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ack0",   64'(if0.ack),   64'd0);
    check("rst.resp0",  64'(if0.resp),  64'd0);
    check("rst.rdata0", 64'(if0.rdata), 64'd0);
    check("rst.busy0",  64'(if0.busy),  64'd0);
    check("rst.busy1",  64'(if1.busy),  64'd0);
`ifdef MEM_SLAVE_ADDR_CHECK_EN
    check("rst.addr_err", 64'(if0.addr_err), 64'd0);
`endif
    rst_n = 1'b1;

    txn(1'b0, 1'b1, 32'h10, 32'hA5A5_0001, 1'b0, '0, '0, "wr10");
    txn(1'b0, 1'b0, 32'h10, '0, 1'b0, '0, 32'hA5A5_0001, "rd10");

    txn(1'b1, 1'b1, 32'h7, 32'h0000_7777, 1'b0, '0, '0, "lat.wr7");
    txn(1'b1, 1'b0, 32'h7, '0, 1'b0, '0, 32'h0000_7777, "lat.rd7");

    // Held req across two writes
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'h3, 32'h3333_0003);
    @(posedge clk);
    a1 = 0; a2 = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (if0.ack) begin
        if (a1 == 0) begin
          a1 = n;
          drive(1'b0, 1'b1, 1'b1, 32'h4, 32'h4444_0004);
        end else begin
          a2 = n;
          if0.req = 1'b0;
        end
      end
    end
    check("held.ack1", 64'(a1), 64'd1);
    check("held.ack2", 64'(a2), 64'd4);
    txn(1'b0, 1'b0, 32'h3, '0, 1'b0, '0, 32'h3333_0003, "held.rd3");
    txn(1'b0, 1'b0, 32'h4, '0, 1'b0, '0, 32'h4444_0004, "held.rd4");

    txn(1'b0, 1'b1, 32'h5, 32'h0000_1111, 1'b1, 32'h0000_2222, '0, "chg.wr5");
    txn(1'b0, 1'b0, 32'h5, '0, 1'b0, '0, 32'h0000_1111, "chg.rd5");

    txn(1'b0, 1'b1, 32'h105, 32'h0000_CAFE, 1'b0, '0, '0, "wrap.wr105");
    txn(1'b0, 1'b1, 32'h0, 32'h0000_BEEF, 1'b0, '0, '0, "wrap.wr0");
`ifdef MEM_SLAVE_ADDR_CHECK_EN
    txn(1'b0, 1'b0, 32'h5,   '0, 1'b0, '0, 32'h0000_1111, "chk.rd5");
    txn(1'b0, 1'b0, 32'h105, '0, 1'b0, '0, 32'hEEEE_EEEE, "chk.rd105");
    txn(1'b0, 1'b0, 32'h100, '0, 1'b0, '0, 32'hEEEE_EEEE, "chk.rd100");
    check("chk.addr_err0", 64'(if0.addr_err), 64'd1);
    check("chk.addr_err1", 64'(if1.addr_err), 64'd0);
`else
    txn(1'b0, 1'b0, 32'h5,   '0, 1'b0, '0, 32'h0000_CAFE, "wrap.rd5");
    txn(1'b0, 1'b0, 32'h105, '0, 1'b0, '0, 32'h0000_CAFE, "wrap.rd105");
    txn(1'b0, 1'b0, 32'h100, '0, 1'b0, '0, 32'h0000_BEEF, "wrap.rd100");
`endif
    txn(1'b0, 1'b0, 32'h0, '0, 1'b0, '0, 32'h0000_BEEF, "wrap.rd0");

    // Reset during dut1's WAIT_RESP
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h7, '0);
    @(posedge clk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (if1.ack) if1.req = 1'b0;
    end
    check("mid.busy", 64'(if1.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid.ack",   64'(if1.ack),   64'd0);
    check("mid.resp",  64'(if1.resp),  64'd0);
    check("mid.rdata", 64'(if1.rdata), 64'd0);
    check("mid.busy0", 64'(if1.busy),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    late_resp = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (if1.resp) late_resp++;
    end
    check("mid.no_resp", 64'(late_resp), 64'd0);
    txn(1'b1, 1'b0, 32'h7, '0, 1'b0, '0, 32'h0000_7777, "mid.rd7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cross_bar_mem_slave.md
Name: cross_bar_mem_slave

Overview:
- Memory-backed responder for the crossbar slave port. It is the far end of the req/addr/cmd/wdata → ack/resp/rdata protocol that the crossbar's slave-side mux drives and tracks.
- Accepts one transaction at a time and answers with a programmable ack latency. Reads additionally return data with a programmable response latency.
- Instantiated once per crossbar slave port in the system and testbench tops. Replaces ad-hoc behavioural slave models.

Parameters:
- ADDR_WIDTH, 32, width of addr port.
- DATA_WIDTH, 32, width of wdata/rdata and of each memory word.
- MEM_DEPTH, 256, number of words; power of two, ≥2.
- ACK_DELAY, 1, cycles from request capture to the ack pulse; ≥1.
- RESP_DELAY, 1, cycles from the ack pulse to the resp pulse on reads; ≥1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  request from crossbar; held until ack.
- addr  input  ADDR_WIDTH  word address; low $clog2(MEM_DEPTH) bits index memory.
- cmd  input  1  1 = write, 0 = read.
- wdata  input  DATA_WIDTH  write data.
- ack  output  1  one-cycle request acknowledge.
- resp  output  1  one-cycle read response; rdata valid in the same cycle.
- rdata  output  DATA_WIDTH  read data; 0 whenever resp = 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: ack, resp, busy = 0; rdata = 0; FSM → IDLE; delay counter cleared. Memory contents are not reset. Reset asserted mid-transaction abandons the transaction with no memory update unless the write edge already occurred.
- FSM states: IDLE, WAIT_ACK, WAIT_RESP, DONE.
- IDLE: on an edge with req = 1, capture addr, cmd and wdata into registers. Load the counter with ACK_DELAY-1 and go to WAIT_ACK. While req = 0, stay in IDLE.
- WAIT_ACK: decrement the counter each cycle. ack is driven high for exactly one cycle once the counter reaches 0.
  - ACK_DELAY = 1 means ack is high in the first cycle after capture.
  - ack is never combinational from req. This guarantees the crossbar's tracker, which samples ack from the cycle after grant, never misses it.
- On the ack cycle, for a write: write the captured wdata into mem[captured index] at that clock edge, then go to DONE.
- On the ack cycle, for a read: latch mem[captured index] into the read register at that edge. Load the counter with RESP_DELAY-1 and go to WAIT_RESP.
- WAIT_RESP: count down. resp = 1 and rdata = latched word for exactly one cycle, then go to DONE. resp is never in the same cycle as ack.
- DONE: one dead cycle; req is ignored; go to IDLE. This gives the arbiter one cycle to revoke or reassign the grant. A req held continuously high is accepted again in IDLE as a new transaction.
- Input changes after capture are ignored. Data and command are taken only from the capture registers.
- Address wrap: bits above $clog2(MEM_DEPTH) are ignored, so addr = MEM_DEPTH aliases to word 0.
- Read-after-write to the same address in back-to-back transactions returns the new data.
- Counter width: $clog2(max(ACK_DELAY, RESP_DELAY)+1); the counter never underflows.

Optional Feature:
- Macro: MEM_SLAVE_ADDR_CHECK_EN.
- When defined, any set addr bit at or above $clog2(MEM_DEPTH) marks the transaction out of range.
  - Out-of-range write: acked normally, memory not modified.
  - Out-of-range read: acked normally; resp returns rdata = {DATA_WIDTH/4{4'hE}}, i.e. 0xEEEEEEEE for 32-bit.
  - A sticky output addr_err (1 bit, reset 0) rises on the ack cycle of the first out-of-range access. It is cleared only by reset.
- When undefined: addresses wrap as described, no addr_err port exists, and the timing is identical in both builds.

Test Plan:
- Write then read, defaults: write addr 0x10 data 0xA5A5_0001.
  - ack in the 1st cycle after req is seen; resp = 0 throughout.
  - Read addr 0x10: ack at +1, resp at +2 with rdata 0xA5A5_0001, rdata = 0 in every other cycle.
- Latency, ACK_DELAY = 3, RESP_DELAY = 4, read: ack exactly 3 cycles after capture, resp exactly 4 cycles after ack. busy is high from capture through DONE.
- Held req: req stays high over two writes to addr 0x3 and 0x4 (inputs changed after the first ack). Two acks separated by the DONE cycle, and memory holds both words.
- Input change mid-transaction: after capture of a write to 0x5 with data 0x1111, change wdata to 0x2222 before ack. Readback of 0x5 returns 0x1111.
- Wrap / check, MEM_DEPTH = 256:
  - Without the macro, a write to addr 0x105 data 0xCAFE, then a read of 0x05, returns 0xCAFE.
  - With MEM_SLAVE_ADDR_CHECK_EN, the same write leaves 0x05 unchanged, a read of 0x105 returns 0xEEEEEEEE, and addr_err goes to 1.
- Reset mid-read: assert rst_n = 0 during WAIT_RESP. ack, resp, rdata and busy go to 0 immediately with no resp pulse after release, and the next request is served normally.
